// File: rtl/counter_pkg.sv
// Shared types and constant helpers for the multimode counter family.
package counter_pkg;

   typedef enum logic {
      UP   = 1'b0,
      DOWN = 1'b1
   } dir_e;

   typedef enum logic {
      WRAP     = 1'b0,
      SATURATE = 1'b1
   } bound_e;

   // Number of bits needed to hold values 0..v-1, never less than one.
   function automatic int clog2(input int v);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/counter_multimode_next.sv
// Combinational next-state unit: one step up or down with wrap or clamp at the bounds.
module counter_multimode_next
   import counter_pkg::*;
#(
   parameter int MAX   = 16,
   parameter int WIDTH = clog2(MAX)
) (
   input  logic [WIDTH-1:0] state_i,
   input  logic [WIDTH-1:0] s_i,
   input  dir_e             down_i,
   input  bound_e           saturate_i,
   output logic [WIDTH-1:0] next_o,
   output logic             tc_o
);

   localparam logic [WIDTH:0]   MAX_W = (WIDTH+1)'(MAX);
   localparam logic [WIDTH:0]   TOP_W = (WIDTH+1)'(MAX - 1);
   localparam logic [WIDTH-1:0] TOP_N = WIDTH'(MAX - 1);

   logic [WIDTH:0]   sumUp;
   logic [WIDTH-1:0] wrapUp;
   logic [WIDTH-1:0] wrapDown;

   // One extra bit keeps state+s exact, so the bound test never sees a silent overflow.
   always_comb begin
      sumUp    = {1'b0, state_i} + {1'b0, s_i};
      wrapUp   = WIDTH'(sumUp - MAX_W);
      wrapDown = WIDTH'({1'b0, state_i} + MAX_W - {1'b0, s_i});
      next_o   = state_i;
      tc_o     = 1'b0;
      if (s_i != '0) begin
         if (down_i == UP) begin
            if (sumUp <= TOP_W) begin
               next_o = sumUp[WIDTH-1:0];
            end else begin
               tc_o   = 1'b1;
               next_o = (saturate_i == SATURATE) ? TOP_N : wrapUp;
            end
         end else begin
            if (state_i >= s_i) begin
               next_o = state_i - s_i;
            end else begin
               tc_o   = 1'b1;
               next_o = (saturate_i == SATURATE) ? '0 : wrapDown;
            end
         end
      end
   end

endmodule

// File: rtl/counter_multimode.sv
// Modulo counter with direction, programmable step, wrap/saturate and an output delay line.
// Optional q==match_val comparator is built when COUNTER_MULTIMODE_MATCH_EN is defined.
module counter_multimode
   import counter_pkg::*;
#(
   parameter int MAX        = 16,
   parameter int WIDTH      = clog2(MAX),
   parameter int STEP_WIDTH = 4,
   parameter int DELAY      = 0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [WIDTH-1:0]      d,
   input  logic                  load,
   input  logic                  enable,
   input  logic                  down,
   input  logic [STEP_WIDTH-1:0] step,
   input  logic                  saturate,
   output logic [WIDTH-1:0]      q,
   output logic                  tc
`ifdef COUNTER_MULTIMODE_MATCH_EN
   ,
   input  logic [WIDTH-1:0]      match_val,
   output logic                  match
`endif
);

   localparam int TOP = MAX - 1;

   logic [WIDTH-1:0] state_q, state_d;
   logic             tc_q, tc_d;
   logic [WIDTH-1:0] stepEff;
   logic [WIDTH-1:0] loadVal;
   logic [WIDTH-1:0] nextState;
   logic             nextTc;

   // Out-of-range step and load values are clamped to the top of the count range.
   always_comb begin
      stepEff = (int'(step) > TOP) ? WIDTH'(TOP) : WIDTH'(step);
      loadVal = (int'(d) > TOP) ? WIDTH'(TOP) : d;
   end

   counter_multimode_next #(
      .MAX   (MAX),
      .WIDTH (WIDTH)
   ) uNext (
      .state_i    (state_q),
      .s_i        (stepEff),
      .down_i     (dir_e'(down)),
      .saturate_i (bound_e'(saturate)),
      .next_o     (nextState),
      .tc_o       (nextTc)
   );

   always_comb begin
      state_d = state_q;
      tc_d    = 1'b0;
      if (load) begin
         state_d = loadVal;
      end else if (enable) begin
         state_d = nextState;
         tc_d    = nextTc;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= '0;
         tc_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         tc_q    <= tc_d;
      end
   end

   generate
      if (DELAY == 0) begin : gNoDelay
         assign q  = state_q;
         assign tc = tc_q;
      end else begin : gDelay
         logic [WIDTH-1:0] qPipe_q [DELAY];
         logic [DELAY-1:0] tcPipe_q;

         // q and tc travel through the same number of stages so they stay aligned.
         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               for (int i = 0; i < DELAY; i++) qPipe_q[i] <= '0;
               tcPipe_q <= '0;
            end else begin
               qPipe_q[0]  <= state_q;
               tcPipe_q[0] <= tc_q;
               for (int i = 1; i < DELAY; i++) begin
                  qPipe_q[i]  <= qPipe_q[i-1];
                  tcPipe_q[i] <= tcPipe_q[i-1];
               end
            end
         end

         assign q  = qPipe_q[DELAY-1];
         assign tc = tcPipe_q[DELAY-1];
      end
   endgenerate

`ifdef COUNTER_MULTIMODE_MATCH_EN
   assign match = (q == match_val);
`endif

endmodule

// File: tb/tb_counter_multimode.sv
// Scoreboard bench driving three counter configurations (MAX=10, MAX=16, MAX=10 with DELAY=2) from shared inputs.
module tb_counter_multimode;

   typedef struct packed {
      logic [3:0] q;
      logic       tc;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] d;
   logic       load;
   logic       enable;
   logic       down;
   logic [3:0] step;
   logic       saturate;
   logic [3:0] matchVal;

   logic [3:0] q10, q16, qD;
   logic       tc10, tc16, tcD;
   logic       match10, match16, matchD;

   int testCount = 0;
   int failCount = 0;

   int st10, st16, stD;
   exp_t sb10[$];
   exp_t sb16[$];
   exp_t sbD[$];

   always #5 clock = ~clock;

   counter_multimode #(.MAX(10)) dut10 (
      .clock(clock), .reset(reset), .d(d), .load(load), .enable(enable), .down(down),
      .step(step), .saturate(saturate), .q(q10), .tc(tc10)
`ifdef COUNTER_MULTIMODE_MATCH_EN
      , .match_val(matchVal), .match(match10)
`endif
   );

   counter_multimode #(.MAX(16)) dut16 (
      .clock(clock), .reset(reset), .d(d), .load(load), .enable(enable), .down(down),
      .step(step), .saturate(saturate), .q(q16), .tc(tc16)
`ifdef COUNTER_MULTIMODE_MATCH_EN
      , .match_val(matchVal), .match(match16)
`endif
   );

   counter_multimode #(.MAX(10), .DELAY(2)) dutD (
      .clock(clock), .reset(reset), .d(d), .load(load), .enable(enable), .down(down),
      .step(step), .saturate(saturate), .q(qD), .tc(tcD)
`ifdef COUNTER_MULTIMODE_MATCH_EN
      , .match_val(matchVal), .match(matchD)
`endif
   );

`ifndef COUNTER_MULTIMODE_MATCH_EN
   assign match10 = 1'b0;
   assign match16 = 1'b0;
   assign matchD  = 1'b0;
`endif

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
      testCount++;
      assert (obs === expv) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Reference behaviour written directly from the counting rules in plain integers.
   task automatic modelStep(input int maxv, inout int st, output logic tcx);
      int s;
      tcx = 1'b0;
      if (load) begin
         st = (int'(d) > maxv - 1) ? maxv - 1 : int'(d);
      end else if (enable) begin
         s = (int'(step) > maxv - 1) ? maxv - 1 : int'(step);
         if (s != 0) begin
            if (!down) begin
               if (st + s <= maxv - 1) st = st + s;
               else begin
                  tcx = 1'b1;
                  st  = saturate ? maxv - 1 : st + s - maxv;
               end
            end else begin
               if (st >= s) st = st - s;
               else begin
                  tcx = 1'b1;
                  st  = saturate ? 0 : st + maxv - s;
               end
            end
         end
      end
   endtask

   task automatic resetModels();
      st10 = 0;
      st16 = 0;
      stD  = 0;
      sb10.delete();
      sb16.delete();
      sbD.delete();
      sbD.push_back('{q: 4'd0, tc: 1'b0});
      sbD.push_back('{q: 4'd0, tc: 1'b0});
   endtask

   task automatic checkOne(input string tag, inout exp_t sb[$], input logic [3:0] qObs,
                           input logic tcObs, input logic mObs);
      exp_t e;
      testCount++;
      assert (sb.size() != 0) else begin
         failCount++;
         $error("[TB] FAIL %s_empty observed=%0d expected=1", tag, sb.size());
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check({tag, "_q"}, qObs, e.q);
         check({tag, "_tc"}, {3'b0, tcObs}, {3'b0, e.tc});
`ifdef COUNTER_MULTIMODE_MATCH_EN
         check({tag, "_match"}, {3'b0, mObs}, {3'b0, (e.q == matchVal)});
`else
         if (mObs !== 1'b0) check({tag, "_match"}, {3'b0, mObs}, 4'd0);
`endif
      end
   endtask

   task automatic checkOutput();
      checkOne("m10", sb10, q10, tc10, match10);
      checkOne("m16", sb16, q16, tc16, match16);
      checkOne("dly", sbD, qD, tcD, matchD);
   endtask

   task automatic applyStimulus(input logic l, input logic en, input logic dn,
                                input logic [3:0] stp, input logic sat, input logic [3:0] dv);
      logic t;
      load     = l;
      enable   = en;
      down     = dn;
      step     = stp;
      saturate = sat;
      d        = dv;
      modelStep(10, st10, t);
      sb10.push_back('{q: 4'(st10), tc: t});
      modelStep(16, st16, t);
      sb16.push_back('{q: 4'(st16), tc: t});
      modelStep(10, stD, t);
      sbD.push_back('{q: 4'(stD), tc: t});
      @(posedge clock);
      #1;
      checkOutput();
   endtask

   task automatic checkAllZero(input string tag);
      check({tag, "_q10"}, q10, 4'd0);
      check({tag, "_tc10"}, {3'b0, tc10}, 4'd0);
      check({tag, "_q16"}, q16, 4'd0);
      check({tag, "_qD"}, qD, 4'd0);
      check({tag, "_tcD"}, {3'b0, tcD}, 4'd0);
`ifdef COUNTER_MULTIMODE_MATCH_EN
      check({tag, "_match10"}, {3'b0, match10}, 4'd0);
`endif
   endtask

   // Asserts reset between edges, checks the immediate clear, holds it across an enabled edge.
   task automatic doReset(input string tag);
      reset  = 1'b1;
      load   = 1'b0;
      enable = 1'b1;
      step   = 4'd1;
      down   = 1'b0;
      #1;
      checkAllZero({tag, "_async"});
      resetModels();
      @(posedge clock);
      #1;
      checkAllZero({tag, "_held"});
      #2;
      reset  = 1'b0;
      enable = 1'b0;
   endtask

   initial begin
      reset    = 1'b1;
      d        = '0;
      load     = 1'b0;
      enable   = 1'b0;
      down     = 1'b0;
      step     = '0;
      saturate = 1'b0;
      matchVal = 4'd5;
      #1;
      checkAllZero("por");
      resetModels();
      @(posedge clock);
      #2;
      reset = 1'b0;

      applyStimulus(1, 0, 0, 0, 0, 8);
      applyStimulus(0, 1, 0, 3, 0, 0);
      check("up_wrap_q", q10, 4'd1);
      check("up_wrap_tc", {3'b0, tc10}, 4'd1);
      applyStimulus(0, 0, 0, 3, 0, 0);
      check("hold_tc", {3'b0, tc10}, 4'd0);

      applyStimulus(1, 0, 0, 0, 0, 2);
      applyStimulus(0, 1, 1, 5, 1, 0);
      check("dn_sat1_q", q10, 4'd0);
      check("dn_sat1_tc", {3'b0, tc10}, 4'd1);
      applyStimulus(0, 1, 1, 5, 1, 0);
      check("dn_sat2_q", q10, 4'd0);
      check("dn_sat2_tc", {3'b0, tc10}, 4'd1);

      applyStimulus(1, 1, 0, 1, 0, 7);
      check("load_pri_q", q10, 4'd7);
      check("load_pri_tc", {3'b0, tc10}, 4'd0);
      applyStimulus(1, 0, 0, 0, 0, 12);
      check("load_clamp_q", q10, 4'd9);
      applyStimulus(0, 1, 0, 15, 0, 0);
      check("step_clamp_q", q10, 4'd8);
      check("step_clamp_tc", {3'b0, tc10}, 4'd1);

      applyStimulus(1, 0, 0, 0, 0, 15);
      applyStimulus(0, 1, 0, 1, 0, 0);
      check("m16_wrap_q", q16, 4'd0);
      check("m16_wrap_tc", {3'b0, tc16}, 4'd1);
      applyStimulus(1, 0, 0, 0, 0, 15);
      applyStimulus(0, 1, 0, 1, 1, 0);
      check("m16_sat_q", q16, 4'd15);
      check("m16_sat_tc", {3'b0, tc16}, 4'd1);
      applyStimulus(0, 1, 0, 1, 1, 0);
      applyStimulus(0, 1, 1, 0, 0, 0);
      check("step0_tc", {3'b0, tc16}, 4'd0);

      doReset("rst1");
      applyStimulus(0, 1, 0, 1, 0, 0);
      applyStimulus(0, 1, 0, 1, 0, 0);
      check("dly_lag2_q", qD, 4'd0);
      applyStimulus(0, 1, 0, 1, 0, 0);
      check("dly_lag3_q", qD, 4'd1);
      applyStimulus(0, 1, 0, 1, 0, 0);
      doReset("rst_mid");
      applyStimulus(0, 1, 0, 1, 0, 0);
      applyStimulus(0, 1, 0, 1, 0, 0);
      check("dly_post_lag2_q", qD, 4'd0);
      applyStimulus(0, 1, 0, 1, 0, 0);
      check("dly_post_lag3_q", qD, 4'd1);

      applyStimulus(1, 0, 0, 0, 0, 3);
      for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 1, 0, 0);

      for (int i = 0; i < 300; i++) begin
         applyStimulus(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
                       1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                       1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
         if (i % 4 == 0) matchVal = 4'($urandom_range(0, 9));
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
